asfifo_wr_packer: RTL and testbench

Write-side packer for the PCIe DMA async FIFO path. Accepts narrow beats over a valid/ready stream in the `wr_clk` domain and packs them into wide FIFO words. Each FIFO word carries lane-keep and end-of-packet flags. It drives the FIFO write port (`din`/`wr_en`) and honours its `full` flag, so no beat is lost or duplicated under backpressure.

---
 rtl/asfifo_pkg.sv | 17 +
 rtl/asfifo_wr_packer_if.sv | 29 ++
 rtl/asfifo_wr_packer.sv | 97 +++++++++
 tb/tb_asfifo_wr_packer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/asfifo_pkg.sv
// Shared fifo_din layout helpers for the async FIFO write-side packer and read-side unpacker.
// fifo_din is {last, keep[RATIO-1:0], data[OUT_WIDTH-1:0]}.
package asfifo_pkg;

    function automatic int keep_lsb(input int in_width, input int ratio);
        return in_width * ratio;
    endfunction

    function automatic int last_bit(input int in_width, input int ratio);
        return in_width * ratio + ratio;
    endfunction

    function automatic int fifo_width(input int in_width, input int ratio);
        return in_width * ratio + ratio + 1;
    endfunction

endpackage

// File: rtl/asfifo_wr_packer_if.sv
// Beat stream in, FIFO write port out. The master modport is the packer itself,
// which masters the FIFO write port; slave is the surrounding source/FIFO side.
interface asfifo_wr_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    import asfifo_pkg::*;

    localparam int FIFO_WIDTH = fifo_width(IN_WIDTH, RATIO);

    logic [IN_WIDTH-1:0]   s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [FIFO_WIDTH-1:0] fifo_din;
    logic                  fifo_wr_en;
    logic                  fifo_full;

    modport master (
        input  s_data, s_valid, s_last, fifo_full,
        output s_ready, fifo_din, fifo_wr_en
    );

    modport slave (
        output s_data, s_valid, s_last, fifo_full,
        input  s_ready, fifo_din, fifo_wr_en
    );

endinterface

// File: rtl/asfifo_wr_packer.sv
// Packs narrow valid/ready beats into wide FIFO words with lane-keep and end-of-packet flags,
// holding one completed word in an output register while the FIFO is full.
module asfifo_wr_packer
    import asfifo_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                 wr_clk,
    input  logic                 PresetFull,
    asfifo_wr_packer_if.master   bus,
    output logic                 busy,
    output logic [15:0]          word_count,
    output logic [15:0]          pkt_count
);

    localparam int OUT_WIDTH  = IN_WIDTH * RATIO;
    localparam int FIFO_WIDTH = fifo_width(IN_WIDTH, RATIO);
    localparam int LAST_BIT   = last_bit(IN_WIDTH, RATIO);
    localparam int LANE_W     = $clog2(RATIO);

    logic [OUT_WIDTH-1:0]  acc_data_reg;
    logic [RATIO-1:0]      acc_keep_reg;
    logic [LANE_W-1:0]     lane_reg;
    logic [FIFO_WIDTH-1:0] out_word_reg;
    logic                  out_valid_reg;
    logic [15:0]           word_count_reg;
    logic [15:0]           pkt_count_reg;

    logic [OUT_WIDTH-1:0]  data_next;
    logic [RATIO-1:0]      keep_next;
    logic                  accept;
    logic                  complete;
    logic                  wr_fire;

    // The output register may drain and reload in the same cycle, so a beat is
    // accepted whenever the held word is absent or being written right now.
    assign bus.s_ready    = ~PresetFull & (~out_valid_reg | ~bus.fifo_full);
    assign wr_fire        = out_valid_reg & ~bus.fifo_full & ~PresetFull;
    assign bus.fifo_wr_en = wr_fire;
    assign bus.fifo_din   = out_word_reg;

    assign accept   = bus.s_valid & bus.s_ready;
    assign complete = accept & ((lane_reg == LANE_W'(RATIO - 1)) | bus.s_last);

    // Merge the incoming beat into its lane; lanes above the current one stay zero.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign data_next[gi*IN_WIDTH +: IN_WIDTH] =
                (lane_reg == LANE_W'(gi)) ? bus.s_data : acc_data_reg[gi*IN_WIDTH +: IN_WIDTH];
            assign keep_next[gi] = (lane_reg == LANE_W'(gi)) | acc_keep_reg[gi];
        end
    endgenerate

    always_ff @(posedge wr_clk or posedge PresetFull) begin
        if (PresetFull) begin
            acc_data_reg   <= '0;
            acc_keep_reg   <= '0;
            lane_reg       <= '0;
            out_word_reg   <= '0;
            out_valid_reg  <= 1'b0;
            word_count_reg <= '0;
            pkt_count_reg  <= '0;
        end else begin
            if (accept) begin
                if (complete) begin
                    out_word_reg <= {bus.s_last, keep_next, data_next};
                    acc_data_reg <= '0;
                    acc_keep_reg <= '0;
                    lane_reg     <= '0;
                end else begin
                    acc_data_reg <= data_next;
                    acc_keep_reg <= keep_next;
                    lane_reg     <= lane_reg + LANE_W'(1);
                end
            end

            if (complete) begin
                out_valid_reg <= 1'b1;
            end else if (wr_fire) begin
                out_valid_reg <= 1'b0;
            end

            if (wr_fire) begin
                word_count_reg <= word_count_reg + 16'd1;
                if (out_word_reg[LAST_BIT]) begin
                    pkt_count_reg <= pkt_count_reg + 16'd1;
                end
            end
        end
    end

    assign busy       = out_valid_reg | (lane_reg != '0);
    assign word_count = word_count_reg;
    assign pkt_count  = pkt_count_reg;

endmodule

// File: tb/tb_asfifo_wr_packer.sv
// Directed table-driven bench for asfifo_wr_packer (IN_WIDTH=8, RATIO=4) plus
// hand-written reset, backpressure and counter-wrap sequences.
module tb_asfifo_wr_packer;

    localparam int IN_WIDTH = 8;
    localparam int RATIO    = 4;
    localparam int FW       = IN_WIDTH * RATIO + RATIO + 1;

    logic        wr_clk = 1'b0;
    logic        PresetFull = 1'b1;
    logic        busy;
    logic [15:0] word_count;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    always #5 wr_clk = ~wr_clk;

    asfifo_wr_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

    asfifo_wr_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
        .wr_clk     (wr_clk),
        .PresetFull (PresetFull),
        .bus        (bus.master),
        .busy       (busy),
        .word_count (word_count),
        .pkt_count  (pkt_count)
    );

    typedef struct {
        logic [7:0]    data;
        logic          valid;
        logic          last;
        logic          full;
        logic          exp_ready;
        logic          exp_wr;
        logic [FW-1:0] exp_din;   // zero means "not compared this step"
        logic          exp_busy;
        logic [15:0]   exp_wc;
        logic [15:0]   exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [FW-1:0] w(input logic last, input logic [3:0] keep, input logic [31:0] data);
        return {last, keep, data};
    endfunction

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic l, input logic f,
                                input logic rdy, input logic wr, input logic [FW-1:0] din,
                                input logic bsy, input logic [15:0] wc, input logic [15:0] pc);
        vec_t t;
        t.data = d; t.valid = v; t.last = l; t.full = f;
        t.exp_ready = rdy; t.exp_wr = wr; t.exp_din = din;
        t.exp_busy = bsy; t.exp_wc = wc; t.exp_pc = pc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic l);
        bus.s_data  = d;
        bus.s_valid = v;
        bus.s_last  = l;
    endtask

    initial begin
        drive(8'h00, 1'b1, 1'b0);
        bus.fifo_full = 1'b0;

        // Reset state, with a beat offered to prove s_ready is gated
        #2;
        chk("reset_ready", 64'(bus.s_ready), 64'd0);
        chk("reset_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("reset_din", 64'(bus.fifo_din), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_wc", 64'(word_count), 64'd0);
        chk("reset_pc", 64'(pkt_count), 64'd0);
        @(negedge wr_clk);
        drive(8'h00, 1'b0, 1'b0);
        PresetFull = 1'b0;

        //          data   v  l  f   rdy wr  din                          busy wc  pc
        // Full packet of four beats
        vecs.push_back(mk(8'h11, 1, 0, 0, 1, 0, '0,                          0, 0, 0));
        vecs.push_back(mk(8'h22, 1, 0, 0, 1, 0, '0,                          1, 0, 0));
        vecs.push_back(mk(8'h33, 1, 0, 0, 1, 0, '0,                          1, 0, 0));
        vecs.push_back(mk(8'h44, 1, 1, 0, 1, 0, '0,                          1, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 1, w(1, 4'hF, 32'h44332211),   1, 0, 0));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 0, '0,                          0, 1, 1));
        // Two-beat packet tail
        vecs.push_back(mk(8'hAA, 1, 0, 0, 1, 0, '0,                          0, 1, 1));
        vecs.push_back(mk(8'hBB, 1, 1, 0, 1, 0, '0,                          1, 1, 1));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 1, w(1, 4'h3, 32'h0000BBAA),   1, 1, 1));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 0, '0,                          0, 2, 2));
        // Twelve back-to-back beats, no last
        vecs.push_back(mk(8'hC0, 1, 0, 0, 1, 0, '0,                          0, 2, 2));
        vecs.push_back(mk(8'hC1, 1, 0, 0, 1, 0, '0,                          1, 2, 2));
        vecs.push_back(mk(8'hC2, 1, 0, 0, 1, 0, '0,                          1, 2, 2));
        vecs.push_back(mk(8'hC3, 1, 0, 0, 1, 0, '0,                          1, 2, 2));
        vecs.push_back(mk(8'hC4, 1, 0, 0, 1, 1, w(0, 4'hF, 32'hC3C2C1C0),   1, 2, 2));
        vecs.push_back(mk(8'hC5, 1, 0, 0, 1, 0, '0,                          1, 3, 2));
        vecs.push_back(mk(8'hC6, 1, 0, 0, 1, 0, '0,                          1, 3, 2));
        vecs.push_back(mk(8'hC7, 1, 0, 0, 1, 0, '0,                          1, 3, 2));
        vecs.push_back(mk(8'hC8, 1, 0, 0, 1, 1, w(0, 4'hF, 32'hC7C6C5C4),   1, 3, 2));
        vecs.push_back(mk(8'hC9, 1, 0, 0, 1, 0, '0,                          1, 4, 2));
        vecs.push_back(mk(8'hCA, 1, 0, 0, 1, 0, '0,                          1, 4, 2));
        vecs.push_back(mk(8'hCB, 1, 0, 0, 1, 0, '0,                          1, 4, 2));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 1, w(0, 4'hF, 32'hCBCAC9C8),   1, 4, 2));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 0, '0,                          0, 5, 2));
        // FIFO full: one word fills the output register, then input stalls
        vecs.push_back(mk(8'h01, 1, 0, 1, 1, 0, '0,                          0, 5, 2));
        vecs.push_back(mk(8'h02, 1, 0, 1, 1, 0, '0,                          1, 5, 2));
        vecs.push_back(mk(8'h03, 1, 0, 1, 1, 0, '0,                          1, 5, 2));
        vecs.push_back(mk(8'h04, 1, 0, 1, 1, 0, '0,                          1, 5, 2));
        vecs.push_back(mk(8'h05, 1, 0, 1, 0, 0, w(0, 4'hF, 32'h04030201),   1, 5, 2));
        vecs.push_back(mk(8'h05, 1, 0, 1, 0, 0, w(0, 4'hF, 32'h04030201),   1, 5, 2));
        vecs.push_back(mk(8'h05, 1, 0, 1, 0, 0, w(0, 4'hF, 32'h04030201),   1, 5, 2));
        vecs.push_back(mk(8'h05, 1, 0, 0, 1, 1, w(0, 4'hF, 32'h04030201),   1, 5, 2));
        vecs.push_back(mk(8'h06, 1, 0, 0, 1, 0, '0,                          1, 6, 2));
        vecs.push_back(mk(8'h07, 1, 0, 0, 1, 0, '0,                          1, 6, 2));
        vecs.push_back(mk(8'h08, 1, 0, 0, 1, 0, '0,                          1, 6, 2));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 1, w(0, 4'hF, 32'h08070605),   1, 6, 2));
        vecs.push_back(mk(8'h00, 0, 0, 0, 1, 0, '0,                          0, 7, 2));

        foreach (vecs[i]) begin
            @(negedge wr_clk);
            drive(vecs[i].data, vecs[i].valid, vecs[i].last);
            bus.fifo_full = vecs[i].full;
            #1;
            $display("step %0d: data=%02h v=%0b l=%0b full=%0b -> ready=%0b wr=%0b din=%h busy=%0b wc=%0d pc=%0d",
                     i, vecs[i].data, vecs[i].valid, vecs[i].last, vecs[i].full,
                     bus.s_ready, bus.fifo_wr_en, bus.fifo_din, busy, word_count, pkt_count);
            chk($sformatf("v%0d_ready", i), 64'(bus.s_ready), 64'(vecs[i].exp_ready));
            chk($sformatf("v%0d_wr_en", i), 64'(bus.fifo_wr_en), 64'(vecs[i].exp_wr));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            chk($sformatf("v%0d_wc", i), 64'(word_count), 64'(vecs[i].exp_wc));
            chk($sformatf("v%0d_pc", i), 64'(pkt_count), 64'(vecs[i].exp_pc));
            if (vecs[i].exp_din != '0)
                chk($sformatf("v%0d_din", i), 64'(bus.fifo_din), 64'(vecs[i].exp_din));
        end

        // Reset mid-packet discards the partial word and clears counters
        @(negedge wr_clk); drive(8'h55, 1'b1, 1'b0);
        @(negedge wr_clk); drive(8'h66, 1'b1, 1'b0);
        @(negedge wr_clk); drive(8'h00, 1'b0, 1'b0);
        #2 PresetFull = 1'b1;
        #1;
        $display("mid-reset: ready=%0b wr=%0b busy=%0b wc=%0d pc=%0d", bus.s_ready, bus.fifo_wr_en, busy, word_count, pkt_count);
        chk("midrst_ready", 64'(bus.s_ready), 64'd0);
        chk("midrst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_wc", 64'(word_count), 64'd0);
        chk("midrst_pc", 64'(pkt_count), 64'd0);
        chk("midrst_din", 64'(bus.fifo_din), 64'd0);
        @(negedge wr_clk); PresetFull = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            @(negedge wr_clk); drive(8'(b), 1'b1, 1'b0);
        end
        @(negedge wr_clk); drive(8'h00, 1'b0, 1'b0);
        #1;
        $display("post-reset word: wr=%0b din=%h", bus.fifo_wr_en, bus.fifo_din);
        chk("postrst_wr_en", 64'(bus.fifo_wr_en), 64'd1);
        chk("postrst_din", 64'(bus.fifo_din), 64'(w(0, 4'hF, 32'h04030201)));

        // fifo_full rising mid-cycle gates the write immediately and holds the word
        #1 bus.fifo_full = 1'b1;
        #1;
        chk("fullrise_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("fullrise_din", 64'(bus.fifo_din), 64'(w(0, 4'hF, 32'h04030201)));
        @(negedge wr_clk); #1;
        chk("fullhold_wc", 64'(word_count), 64'd0);
        chk("fullhold_ready", 64'(bus.s_ready), 64'd0);
        @(negedge wr_clk); bus.fifo_full = 1'b0; #1;
        $display("full released: ready=%0b wr=%0b din=%h", bus.s_ready, bus.fifo_wr_en, bus.fifo_din);
        chk("fullfall_wr_en", 64'(bus.fifo_wr_en), 64'd1);
        chk("fullfall_ready", 64'(bus.s_ready), 64'd1);
        @(negedge wr_clk); #1;
        chk("fullfall_wc", 64'(word_count), 64'd1);
        chk("fullfall_wr_once", 64'(bus.fifo_wr_en), 64'd0);
        chk("fullfall_busy", 64'(busy), 64'd0);

        // Counter wrap: 65535 single-beat packets, then one more
        @(negedge wr_clk); PresetFull = 1'b1;
        @(negedge wr_clk); PresetFull = 1'b0;
        for (int n = 0; n < 65535; n++) begin
            @(negedge wr_clk); drive(8'(n), 1'b1, 1'b1);
        end
        @(negedge wr_clk); drive(8'h00, 1'b0, 1'b0);
        @(negedge wr_clk); #1;
        $display("after 65535 words: wc=%0h pc=%0h busy=%0b", word_count, pkt_count, busy);
        chk("pre_wrap_wc", 64'(word_count), 64'hFFFF);
        chk("pre_wrap_pc", 64'(pkt_count), 64'hFFFF);
        chk("pre_wrap_busy", 64'(busy), 64'd0);
        @(negedge wr_clk); drive(8'h5A, 1'b1, 1'b1);
        @(negedge wr_clk); drive(8'h00, 1'b0, 1'b0); #1;
        chk("wrap_din", 64'(bus.fifo_din), 64'(w(1, 4'h1, 32'h0000005A)));
        chk("wrap_wr_en", 64'(bus.fifo_wr_en), 64'd1);
        @(negedge wr_clk); #1;
        $display("after wrap word: wc=%0h pc=%0h", word_count, pkt_count);
        chk("wrap_wc", 64'(word_count), 64'h0000);
        chk("wrap_pc", 64'(pkt_count), 64'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
